pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 111 +++++++++++
 tb/tb_pc_stack_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with an integrated return-address stack.
// The PC is updated once per clock from the op code; calls push the
// sequential address onto a circular return stack and returns pop it.
// The stack silently overwrites its oldest entry on overflow and returns
// the sequential address on underflow; both cases set a sticky error flag.
module pc_stack_unit #(
  parameter int               WIDTH       = 32,
  parameter int               RAS_DEPTH   = 8,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               INSTR_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             pc_in,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_seq,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_err
);

  // RAS_DEPTH must be a power of two (>= 2) so the top pointer wraps
  // naturally at PW bits.
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_HOLD    = 3'b000;
  localparam logic [2:0] OP_INC     = 3'b001;
  localparam logic [2:0] OP_LOAD    = 3'b010;
  localparam logic [2:0] OP_REL     = 3'b011;
  localparam logic [2:0] OP_CALL_A  = 3'b100;
  localparam logic [2:0] OP_CALL_R  = 3'b101;
  localparam logic [2:0] OP_RET     = 3'b110;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  logic [WIDTH-1:0] pc_q;
  logic [PW-1:0]    top_q;
  logic [CW-1:0]    count_q;
  logic             err_q;
  logic [WIDTH-1:0] mem [RAS_DEPTH];

  logic [WIDTH-1:0] rel_tgt;
  logic [PW-1:0]    top_nxt;
  logic             do_push;

  // pc_in is a signed instruction offset; modulo-2^WIDTH arithmetic makes
  // the two's-complement interpretation fall out of a plain multiply/add.
  assign pc_seq    = pc_q + STEP;
  assign rel_tgt   = pc_q + (pc_in * STEP) + STEP;
  assign top_nxt   = top_q + PW'(1);
  assign do_push   = !stall && (op == OP_CALL_A || op == OP_CALL_R);

  assign pc_out    = pc_q;
  assign ras_count = count_q;
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));
  assign ras_err   = err_q;
  assign ras_top   = ras_empty ? '0 : mem[top_q];

  // Stack storage: written on push only, never reset (stale entries are
  // hidden by ras_count).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[top_nxt] <= pc_seq;
    end
  end

  // PC, stack pointer, occupancy and sticky error update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      top_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      case (op)
        OP_INC:  pc_q <= pc_seq;
        OP_LOAD: pc_q <= pc_in;
        OP_REL:  pc_q <= rel_tgt;
        OP_CALL_A, OP_CALL_R: begin
          pc_q  <= (op == OP_CALL_A) ? pc_in : rel_tgt;
          top_q <= top_nxt;
          // On overflow the pointer still advances, so the write lands on
          // the oldest entry and the count stays saturated.
          if (ras_full) begin
            err_q <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_q  <= pc_seq;
            err_q <= 1'b1;
          end else begin
            pc_q    <= mem[top_q];
            top_q   <= top_q - PW'(1);
            count_q <= count_q - CW'(1);
          end
        end
        default: ;  // hold and reserved leave everything unchanged
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: stimulus updates a queue-based
// reference model and pushes the expected post-edge state; a monitor pops
// and compares after each rising edge.
module tb_pc_stack_unit;

  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out, pc_seq, ras_top;
  logic [3:0]  ras_count;
  logic        ras_empty, ras_full, ras_err;

  pc_stack_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .pc_in(pc_in),
    .pc_out(pc_out), .pc_seq(pc_seq), .ras_top(ras_top),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] top;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc  = m_pc;
    e.top = (m_stk.size() == 0) ? 32'h0 : m_stk[$];
    e.cnt = m_stk.size();
    e.err = m_err;
    return e;
  endfunction

  function automatic void model_push(input logic [31:0] v);
    if (m_stk.size() == 8) begin
      void'(m_stk.pop_front());
      m_err = 1'b1;
    end
    m_stk.push_back(v);
  endfunction

  function automatic void model_step(input bit st, input logic [2:0] o, input logic [31:0] pin);
    logic [31:0] seq, rel;
    if (st) return;
    seq = m_pc + 32'd4;
    rel = m_pc + pin * 32'd4 + 32'd4;
    case (o)
      3'd1: m_pc = seq;
      3'd2: m_pc = pin;
      3'd3: m_pc = rel;
      3'd4: begin model_push(seq); m_pc = pin; end
      3'd5: begin model_push(seq); m_pc = rel; end
      3'd6: begin
        if (m_stk.size() == 0) begin m_pc = seq; m_err = 1'b1; end
        else m_pc = m_stk.pop_back();
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_pc = RV;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  task automatic step(input bit st, input logic [2:0] o, input logic [31:0] pin);
    @(negedge clk);
    stall = st; op = o; pc_in = pin;
    model_step(st, o, pin);
    sb.push_back(model_snapshot());
  endtask

  // Asynchronous reset pulse between edges; state must clear before any edge.
  task automatic reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pc", pc_out, RV);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_count", {28'b0, ras_count}, 32'd0);
    check("rst_err", {31'b0, ras_err}, 32'd0);
    stall = 1'b0; op = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the DUT against the next expected state after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_out", pc_out, e.pc);
        check("pc_seq", pc_seq, e.pc + 32'd4);
        check("ras_top", ras_top, e.top);
        check("ras_count", {28'b0, ras_count}, e.cnt);
        check("ras_err", {31'b0, ras_err}, {31'b0, e.err});
        check("ras_empty", {31'b0, ras_empty}, (e.cnt == 0) ? 32'd1 : 32'd0);
        check("ras_full", {31'b0, ras_full}, (e.cnt == 8) ? 32'd1 : 32'd0);
      end
    end
  end

  initial begin
    int guard;
    logic [31:0] pin;
    model_reset();
    #12;
    check("init_pc", pc_out, RV);
    check("init_count", {28'b0, ras_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three increments from reset.
    for (int i = 0; i < 3; i++) step(1'b0, 3'd1, 32'h0);
    step(1'b0, 3'd0, 32'h0);
    check("inc_pc_final", m_pc, 32'd12);

    // Relative call with a negative offset.
    step(1'b0, 3'd2, 32'h100);
    step(1'b0, 3'd5, 32'hFFFF_FFFE);
    step(1'b0, 3'd0, 32'h0);

    // Nine absolute calls overflow the stack, then eight returns drain it.
    reset_mid();
    for (int k = 1; k <= 9; k++) step(1'b0, 3'd4, 32'h1000 * k);
    for (int k = 0; k < 8; k++) step(1'b0, 3'd6, 32'h0);
    step(1'b0, 3'd0, 32'h0);

    // Return on an empty stack.
    reset_mid();
    step(1'b0, 3'd2, 32'h40);
    step(1'b0, 3'd6, 32'h0);

    // Stalled call, then the call released exactly once.
    step(1'b0, 3'd2, 32'h200);
    step(1'b1, 3'd4, 32'h300);
    step(1'b1, 3'd4, 32'h300);
    step(1'b0, 3'd4, 32'h300);
    step(1'b0, 3'd0, 32'h0);

    // Three calls, then reset in mid-sequence; first op after acts on reset state.
    for (int k = 0; k < 3; k++) step(1'b0, 3'd4, 32'h500 + 32'h10 * k);
    reset_mid();
    step(1'b0, 3'd6, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_mid();
      end else begin
        if ($urandom_range(0, 1) == 1) pin = $urandom;
        else pin = 32'($signed($urandom_range(0, 64)) - 32);
        step($urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), pin);
      end
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
